// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the 6502-compatible cpu core and its ALU.
//   alu_mode_e      : 5-bit ALU operation select (values 6..31 reserved)
//   P_* constants   : bit positions of the flags inside the P status register
// ---------------------------------------------------------------------------
package cpu_pkg;

    typedef enum logic [4:0] {
        ALU_ADD = 5'd0,
        ALU_AND = 5'd1,
        ALU_OR  = 5'd2,
        ALU_EOR = 5'd3,
        ALU_SR  = 5'd4,
        ALU_SUB = 5'd5
    } alu_mode_e;

    // Status register (P) bit positions.
    localparam int P_C = 0;
    localparam int P_Z = 1;
    localparam int P_I = 2;
    localparam int P_D = 3;
    localparam int P_B = 4;
    localparam int P_U = 5;
    localparam int P_V = 6;
    localparam int P_N = 7;

endpackage

// File: rtl/alu.sv
// ---------------------------------------------------------------------------
// alu
// Eight-bit arithmetic/logic unit with registered result and N/V/Z/C flags.
// Results appear one cycle after the operands are sampled.
// Ports:
//   clk        in   clock, rising edge active
//   reset      in   synchronous active-low reset
//   alu_a      in   [7:0] operand A (accumulator side, shift source)
//   alu_b      in   [7:0] operand B (memory/data side)
//   mode       in   [4:0] operation select (see cpu_pkg::alu_mode_e)
//   carry_in   in   carry into ADD/SUB, bit shifted into bit 7 for SR
//   alu_out    out  [7:0] registered result
//   carry_out  out  registered carry (C)
//   overflow   out  registered signed overflow (V)
//   zero       out  registered zero flag (Z)
//   sign       out  registered negative flag (N)
// ---------------------------------------------------------------------------
module alu
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] alu_a,
    input  logic [7:0] alu_b,
    input  logic [4:0] mode,
    input  logic       carry_in,
    output logic [7:0] alu_out,
    output logic       carry_out,
    output logic       overflow,
    output logic       zero,
    output logic       sign
);

    logic       is_sub;
    logic [7:0] b_op;
    logic [8:0] sum;
    logic [7:0] res_next;
    logic       c_next;
    logic       v_next;

    // One adder serves both ADD and SUB; SUB feeds it the inverted operand,
    // so carry_in=1 gives a plain subtract and C=1 means "no borrow".
    // The overflow rule a[7]==b_op[7] covers both cases because b_op is
    // already inverted for SUB.  Reserved modes fall through to ADD.
    always_comb begin
        is_sub   = (mode == ALU_SUB);
        b_op     = is_sub ? ~alu_b : alu_b;
        sum      = {1'b0, alu_a} + {1'b0, b_op} + {8'b0, carry_in};
        res_next = sum[7:0];
        c_next   = sum[8];
        v_next   = (alu_a[7] == b_op[7]) && (sum[7] != alu_a[7]);
        case (mode)
            ALU_AND: begin
                res_next = alu_a & alu_b;
                c_next   = 1'b0;
                v_next   = 1'b0;
            end
            ALU_OR: begin
                res_next = alu_a | alu_b;
                c_next   = 1'b0;
                v_next   = 1'b0;
            end
            ALU_EOR: begin
                res_next = alu_a ^ alu_b;
                c_next   = 1'b0;
                v_next   = 1'b0;
            end
            ALU_SR: begin
                res_next = {carry_in, alu_a[7:1]};
                c_next   = alu_a[0];
                v_next   = 1'b0;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            alu_out   <= 8'h00;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
            sign      <= 1'b0;
        end else begin
            alu_out   <= res_next;
            carry_out <= c_next;
            overflow  <= v_next;
            zero      <= (res_next == 8'h00);
            sign      <= res_next[7];
        end
    end

endmodule

// File: tb/tb_alu.sv
// ---------------------------------------------------------------------------
// tb_alu
// Self-checking bench for alu: directed cases with known answers, then
// randomized back-to-back operations compared against an arithmetic model.
// ---------------------------------------------------------------------------
module tb_alu;
    import cpu_pkg::*;

    logic       clk;
    logic       reset;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [4:0] mode;
    logic       carry_in;
    logic [7:0] alu_out;
    logic       carry_out;
    logic       overflow;
    logic       zero;
    logic       sign;

    int total_count;
    int bad_count;

    alu dut (
        .clk       (clk),
        .reset     (reset),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .mode      (mode),
        .carry_in  (carry_in),
        .alu_out   (alu_out),
        .carry_out (carry_out),
        .overflow  (overflow),
        .zero      (zero),
        .sign      (sign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input int observed, input int expected);
        total_count++;
        if (observed !== expected) begin
            bad_count++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drive one operation, let it pass one rising edge, then settle.
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                                 input logic [4:0] m, input logic cin);
        alu_a    = a;
        alu_b    = b;
        mode     = m;
        carry_in = cin;
        @(posedge clk);
        #1;
    endtask

    // Reference model from plain integer arithmetic; returns {N,Z,V,C,R}.
    function automatic logic [11:0] refModel(input int a, input int b, input int m, input int cin);
        int r, c, v, sa, sb, s;
        sa = (a >= 128) ? a - 256 : a;
        sb = (b >= 128) ? b - 256 : b;
        c = 0;
        v = 0;
        if (m == 1) r = a & b;
        else if (m == 2) r = a | b;
        else if (m == 3) r = a ^ b;
        else if (m == 4) begin
            r = cin * 128 + a / 2;
            c = a % 2;
        end else if (m == 5) begin
            s = a - b - (1 - cin);
            c = (s >= 0) ? 1 : 0;
            r = (s + 256) % 256;
            s = sa - sb - (1 - cin);
            v = (s < -128 || s > 127) ? 1 : 0;
        end else begin
            s = a + b + cin;
            c = (s > 255) ? 1 : 0;
            r = s % 256;
            s = sa + sb + cin;
            v = (s < -128 || s > 127) ? 1 : 0;
        end
        return {(r >= 128) ? 1'b1 : 1'b0, (r == 0) ? 1'b1 : 1'b0, v[0], c[0], r[7:0]};
    endfunction

    task automatic checkAll(input string tag, input logic [7:0] er, input logic ec,
                            input logic ev, input logic ez, input logic en);
        checkOutput({tag, ".out"}, alu_out,   er);
        checkOutput({tag, ".C"},   carry_out, ec);
        checkOutput({tag, ".V"},   overflow,  ev);
        checkOutput({tag, ".Z"},   zero,      ez);
        checkOutput({tag, ".N"},   sign,      en);
    endtask

    task automatic directed(input string tag, input logic [7:0] a, input logic [7:0] b,
                            input logic [4:0] m, input logic cin, input logic [7:0] er,
                            input logic ec, input logic ev, input logic ez, input logic en);
        applyStimulus(a, b, m, cin);
        checkAll(tag, er, ec, ev, ez, en);
    endtask

    initial begin
        logic [11:0] exp_v;
        logic [7:0]  ra;
        logic [7:0]  rb;
        logic [4:0]  rm;
        logic        rc;
        total_count = 0;
        bad_count   = 0;

        // Reset dominates an ADD that would otherwise set C and Z.
        reset = 1'b0;
        applyStimulus(8'hFF, 8'h01, ALU_ADD, 1'b0);
        checkAll("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        applyStimulus(8'hFF, 8'h01, ALU_ADD, 1'b0);
        checkAll("first", 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);

        directed("add_ovf", 8'h50, 8'h50, ALU_ADD, 1'b0, 8'hA0, 1'b0, 1'b1, 1'b0, 1'b1);
        directed("sub_ovf", 8'h80, 8'h01, ALU_SUB, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0, 1'b0);
        directed("sub_brw", 8'h00, 8'h01, ALU_SUB, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1);
        directed("sub_eq",  8'h05, 8'h05, ALU_SUB, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
        directed("and",     8'hF0, 8'h0F, ALU_AND, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        directed("or",      8'hF0, 8'h0F, ALU_OR,  1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1);
        directed("eor",     8'hAA, 8'hFF, ALU_EOR, 1'b0, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
        directed("ror",     8'h81, 8'h3C, ALU_SR,  1'b1, 8'hC0, 1'b1, 1'b0, 1'b0, 1'b1);
        directed("lsr",     8'h01, 8'hFF, ALU_SR,  1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);

        // Back-to-back ADD, AND, reserved mode 7: each result lands one edge later.
        directed("pipe_add", 8'h10, 8'h22, ALU_ADD, 1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 1'b0);
        directed("pipe_and", 8'h10, 8'h22, ALU_AND, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        directed("pipe_rsv", 8'h10, 8'h22, 5'd7,    1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 1'b0);
        directed("rsv31",    8'h7F, 8'h01, 5'd31,   1'b0, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1);

        // Reset mid-stream discards the in-flight result.
        reset = 1'b0;
        applyStimulus(8'hC3, 8'hC3, ALU_ADD, 1'b1);
        checkAll("midrst", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;

        // Randomized operations, mostly defined modes with some reserved ones.
        for (int i = 0; i < 400; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            rm = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(6, 31))
                                              : 5'($urandom_range(0, 5));
            applyStimulus(ra, rb, rm, rc);
            exp_v = refModel(int'(ra), int'(rb), int'(rm), int'(rc));
            checkAll("rand", exp_v[7:0], exp_v[8], exp_v[9], exp_v[10], exp_v[11]);
        end

        $display("test done: total=%0d bad=%0d", total_count, bad_count);
        $finish;
    end

endmodule

// File: doc/alu.md
# alu

Eight-bit arithmetic/logic unit for the 6502-compatible `cpu` core. It computes one of six operations on two byte operands plus a carry input. Result and N/V/Z/C status flags are registered, so they feed the processor status register and the data bus one cycle later.

## Interface
- Parameters: none. The mode encoding lives in the shared package.
- `clk`  in  1  – single clock; all state updates on the rising edge.
- `reset`  in  1  – synchronous, active-low; sampled on the rising edge of `clk`.
- `alu_a`  in  8  – operand A (accumulator side; the shift source).
- `alu_b`  in  8  – operand B (memory/data side).
- `mode`  in  5  – operation select: ADD=0, AND=1, OR=2, EOR=3, SR=4, SUB=5; 6–31 reserved.
- `carry_in`  in  1  – carry into ADD/SUB; bit shifted into bit 7 for SR.
- `alu_out`  out  8  – registered result.
- `carry_out`  out  1  – registered carry (C).
- `overflow`  out  1  – registered signed overflow (V).
- `zero`  out  1  – registered zero flag (Z).
- `sign`  out  1  – registered negative flag (N).

## Operation
- Combinational next-state result R and carry C' per `mode`:
  - ADD: {C',R} = a + b + carry_in (9-bit sum).
  - SUB: {C',R} = a + ~b + carry_in. C'=1 means no borrow (6502 SBC semantics). The caller supplies carry_in=1 for a plain subtract.
  - AND / OR / EOR: R = a & b / a | b / a ^ b; C'=0.
  - SR: R = {carry_in, a[7:1]}; C' = a[0]; `alu_b` ignored. LSR uses carry_in=0; ROR uses carry_in=C.
  - Reserved modes 6–31: behave exactly as ADD.
- V' for ADD: (a[7]==b[7]) && (R[7]!=a[7]).
- V' for SUB: (a[7]!=b[7]) && (R[7]!=a[7]).
- V'=0 for all other modes.
- Z' = (R==8'h00); N' = R[7] for every mode.
- No decimal (BCD) mode. All arithmetic is binary modulo 256; the ninth sum bit goes to carry only.

## Timing
- Reset (reset=0 at a rising edge): alu_out=8'h00, carry_out=0, overflow=0, zero=0, sign=0. Reset dominates any input applied in the same cycle.
- Latency 1: inputs sampled at edge k appear on the outputs after edge k; the outputs hold until the next edge.
- Registered every cycle; no enable, no handshake, no internal state beyond the output registers.
- Reset asserted mid-stream discards the in-flight result.
- The first valid result follows the first edge with reset=1.
- Inputs may change every cycle; back-to-back operations are fully pipelined at throughput 1/cycle.
- Boundary cases:
  - ADD 0xFF+0x01: wraps to 0x00 with C=1.
  - SUB 0x00−0x01 (carry_in=1): wraps to 0xFF with C=0.
  - SR of 0x01 with carry_in=0: gives 0x00, Z=1, C=1.

## Structure
- Shared package `cpu_pkg` holds:
  - the mode constants ALU_ADD…ALU_SUB as a 5-bit typedef'd enum or localparams;
  - status-bit index constants used by the `cpu` P register.
- `cpu` and `alu` both import it; it replaces the file-scope parameters.
- No sub-module is required.
- Internally, one combinational block (adder with B-inversion shared by ADD/SUB, logic unit, shifter, flag logic) feeds one output register block.

## Test plan
- Reset: drive reset=0 with mode=ADD, a=0xFF, b=0x01 → after the edge, all outputs 0. Release reset → next cycle alu_out=0x00, C=1, Z=1, N=0, V=0.
- Signed overflow: ADD a=0x50, b=0x50, cin=0 → 0xA0, V=1, N=1, C=0, Z=0. SUB a=0x80, b=0x01, cin=1 → 0x7F, V=1, C=1, N=0.
- Borrow: SUB a=0x00, b=0x01, cin=1 → 0xFF, C=0, N=1, V=0. SUB a=0x05, b=0x05, cin=1 → 0x00, C=1, Z=1.
- Logic: AND 0xF0,0x0F → 0x00, Z=1, C=0. OR 0xF0,0x0F → 0xFF, N=1. EOR 0xAA,0xFF → 0x55, V=0.
- Shift: SR a=0x81, cin=1 → 0xC0, C=1, N=1. SR a=0x01, cin=0 → 0x00, C=1, Z=1.
- Pipelining/reserved: issue ADD, AND, mode=7 on consecutive cycles (a=0x10, b=0x22, cin=1) → results 0x33, 0x00 (Z=1), 0x33 on the three following cycles, each exactly one cycle after its inputs.
